alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_muldiv_if.sv | 25 ++
 rtl/muldiv_iter.sv | 102 ++++++++++
 rtl/alu_muldiv.sv | 129 ++++++++++++
 tb/tb_alu_muldiv.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, FSM states and op-class helpers.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_SLT   = 4'b0101,
    OP_SLTU  = 4'b0110,
    OP_SLL   = 4'b0111,
    OP_SRL   = 4'b1000,
    OP_SRA   = 4'b1001,
    OP_MUL   = 4'b1010,
    OP_MULHU = 4'b1011,
    OP_DIV   = 4'b1100,
    OP_DIVU  = 4'b1101,
    OP_REM   = 4'b1110,
    OP_REMU  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } alu_state_e;

  // Ops 1010-1111 run on the iterative datapath.
  function automatic logic is_iter_op(alu_op_e op);
    return op[3] & (op[2] | op[1]);
  endfunction

  function automatic logic is_mul_op(alu_op_e op);
    return (op == OP_MUL) || (op == OP_MULHU);
  endfunction

  function automatic logic is_div_op(alu_op_e op);
    return op[3] & op[2];
  endfunction

  function automatic logic is_rem_op(alu_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_div_op(alu_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// Request/response bundle of the ALU.
//   master: drives in_valid, SrcA, SrcB, ALUControl; receives in_ready, ALUResult, Zero, done
//   slave : the ALU side of the same signals
interface alu_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             done;

  modport master (
    output in_valid, SrcA, SrcB, ALUControl,
    input  in_ready, ALUResult, Zero, done
  );

  modport slave (
    input  in_valid, SrcA, SrcB, ALUControl,
    output in_ready, ALUResult, Zero, done
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
//   clk, reset  : clock, async active-high reset
//   start_i     : load operands (first iteration happens on the load edge)
//   op_i        : MUL/MULHU/DIV/DIVU/REM/REMU
//   a_i, b_i    : operands
//   busy_o      : iterations still outstanding
//   result_c_o  : result decoded from the iteration registers (valid once busy_o drops)
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  alu_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] result_c_o
);

  // {hi, lo} is the product for multiply, {remainder, quotient} for divide.
  logic [WIDTH-1:0] hi_q, lo_q, m_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  alu_op_e          op_q;
  logic             q_neg_q, r_neg_q;

  logic             a_neg_c, b_neg_c;
  logic [WIDTH-1:0] lo_init_c, m_init_c;
  logic [2*WIDTH-1:0] start_step_c, iter_step_c;

  // One radix-2 step of either algorithm.
  function automatic logic [2*WIDTH-1:0] step(logic mul, logic [WIDTH-1:0] hi,
                                               logic [WIDTH-1:0] lo, logic [WIDTH-1:0] m);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] lo_sh;
    if (mul) begin
      sum = lo[0] ? ({1'b0, hi} + {1'b0, m}) : {1'b0, hi};
      return {sum, lo[WIDTH-1:1]};
    end
    sh    = {hi, lo[WIDTH-1]};
    lo_sh = {lo[WIDTH-2:0], 1'b0};
    diff  = sh - {1'b0, m};
    // Partial remainder is always below the divisor, so diff fits WIDTH+1 bits signed.
    if (!diff[WIDTH]) return {diff[WIDTH-1:0], lo_sh | WIDTH'(1)};
    return {sh[WIDTH-1:0], lo_sh};
  endfunction

  // Signed divide works on magnitudes; signs are restored on the result.
  always_comb begin
    a_neg_c   = is_signed_div_op(op_i) & a_i[WIDTH-1];
    b_neg_c   = is_signed_div_op(op_i) & b_i[WIDTH-1];
    lo_init_c = a_neg_c ? (-a_i) : a_i;
    m_init_c  = b_neg_c ? (-b_i) : b_i;
    start_step_c = step(is_mul_op(op_i), '0, lo_init_c, m_init_c);
    iter_step_c  = step(is_mul_op(op_q), hi_q, lo_q, m_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      op_q    <= OP_ADD;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (start_i) begin
      {hi_q, lo_q} <= start_step_c;
      m_q          <= m_init_c;
      cnt_q        <= CNT_W'(WIDTH - 1);
      busy_q       <= 1'b1;
      op_q         <= op_i;
      q_neg_q      <= a_neg_c ^ b_neg_c;
      r_neg_q      <= a_neg_c;
    end else if (busy_q) begin
      {hi_q, lo_q} <= iter_step_c;
      cnt_q        <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy_q <= 1'b0;
    end
  end

  always_comb begin
    result_c_o = lo_q;
    case (op_q)
      OP_MUL:          result_c_o = lo_q;
      OP_MULHU:        result_c_o = hi_q;
      OP_DIV, OP_DIVU: result_c_o = q_neg_q ? (-lo_q) : lo_q;
      OP_REM, OP_REMU: result_c_o = r_neg_q ? (-hi_q) : hi_q;
      default:         result_c_o = lo_q;
    endcase
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/alu_muldiv.sv
// ALU with single-cycle logic/arith/shift ops and iterative multiply/divide.
//   clk, reset : clock, async active-high reset
//   bus        : slave side of alu_muldiv_if (in_valid/in_ready request handshake,
//                SrcA/SrcB/ALUControl operands, registered ALUResult/Zero, done pulse)
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  alu_muldiv_if.slave  bus
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  alu_state_e       state_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             done_q;
  logic             in_ready_q;

  alu_op_e          op_c;
  logic [SH_W-1:0]  shamt_c;
  logic [WIDTH-1:0] alu_c;
  logic [WIDTH-1:0] dz_result_c;
  logic             div_zero_c;
  logic             accept_c;
  logic             iter_start_c;
  logic             iter_busy;
  logic [WIDTH-1:0] iter_result_c;

  assign op_c = alu_op_e'(bus.ALUControl);

  // Single-cycle datapath, evaluated on the request operands.
  always_comb begin
    alu_c   = '0;
    shamt_c = bus.SrcB[SH_W-1:0];
    case (op_c)
      OP_ADD:  alu_c = bus.SrcA + bus.SrcB;
      OP_SUB:  alu_c = bus.SrcA - bus.SrcB;
      OP_AND:  alu_c = bus.SrcA & bus.SrcB;
      OP_OR:   alu_c = bus.SrcA | bus.SrcB;
      OP_XOR:  alu_c = bus.SrcA ^ bus.SrcB;
      OP_SLT:  alu_c = WIDTH'($signed(bus.SrcA) < $signed(bus.SrcB));
      OP_SLTU: alu_c = WIDTH'(bus.SrcA < bus.SrcB);
      OP_SLL:  alu_c = bus.SrcA << shamt_c;
      OP_SRL:  alu_c = bus.SrcA >> shamt_c;
      OP_SRA:  alu_c = $unsigned($signed(bus.SrcA) >>> shamt_c);
      default: alu_c = '0;
    endcase
  end

  // Divide-by-zero bypasses the iterator with a fixed answer.
  assign div_zero_c   = is_div_op(op_c) && (bus.SrcB == '0);
  assign dz_result_c  = is_rem_op(op_c) ? bus.SrcA : '1;
  assign accept_c     = bus.in_valid && in_ready_q;
  assign iter_start_c = accept_c && is_iter_op(op_c) && !div_zero_c;

  muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk        (clk),
    .reset      (reset),
    .start_i    (iter_start_c),
    .op_i       (op_c),
    .a_i        (bus.SrcA),
    .b_i        (bus.SrcB),
    .busy_o     (iter_busy),
    .result_c_o (iter_result_c)
  );

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      result_q   <= '0;
      zero_q     <= 1'b1;
      done_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            in_ready_q <= 1'b0;
            if (!is_iter_op(op_c)) begin
              result_q <= alu_c;
              zero_q   <= (alu_c == '0);
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else if (div_zero_c) begin
              result_q <= dz_result_c;
              zero_q   <= (dz_result_c == '0);
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              state_q  <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (!iter_busy) begin
            result_q <= iter_result_c;
            zero_q   <= (iter_result_c == '0);
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.ALUResult = result_q;
  assign bus.Zero      = zero_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv (WIDTH=32), directed vectors.
module tb_alu_muldiv;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_muldiv_if #(.WIDTH(W)) bus ();

  alu_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;

  function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done with ALUResult=0x%08h expected no done", bus.ALUResult);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", bus.ALUResult, mon_exp);
        check("zero", W'(bus.Zero), W'(mon_exp == '0));
      end
    end
  end

  // Issue one request, push its expectation, measure done latency.
  task automatic issue(input alu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input int lat, input bit hold);
    int n;
    int got;
    bit ready_err;
    n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", W'(bus.in_ready), W'(1));
    bus.in_valid   = 1'b1;
    bus.SrcA       = a;
    bus.SrcB       = b;
    bus.ALUControl = op;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (!hold) bus.in_valid = 1'b0;
    else begin
      bus.SrcA       = 32'h1234_5678;
      bus.SrcB       = 32'h0000_0003;
      bus.ALUControl = OP_SUB;
    end
    got       = 0;
    ready_err = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        got = i;
        break;
      end
      if (bus.in_ready !== 1'b0) ready_err = 1'b1;
      if (hold) begin
        bus.SrcA       = $urandom;
        bus.SrcB       = $urandom;
        bus.ALUControl = 4'(i);
      end
    end
    bus.in_valid = 1'b0;
    check($sformatf("latency_op%0h", op), W'(got), W'(lat));
    check($sformatf("ready_low_op%0h", op), W'(ready_err), W'(0));
  endtask

  initial begin
    int dn;
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.SrcA       = '0;
    bus.SrcB       = '0;
    bus.ALUControl = '0;
    repeat (2) @(negedge clk);
    check("rst_result", bus.ALUResult, 32'h0);
    check("rst_zero", W'(bus.Zero), W'(1));
    check("rst_done", W'(bus.done), W'(0));
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", W'(bus.in_ready), W'(1));

    // Single-cycle ops
    issue(OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1'b0);
    issue(OP_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1, 1'b0);
    issue(OP_AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1, 1'b0);
    issue(OP_OR,   32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1, 1'b0);
    issue(OP_XOR,  32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 1, 1'b0);
    issue(OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1, 1'b0);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1'b0);
    issue(OP_SLL,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1, 1'b0);
    issue(OP_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1, 1'b0);
    issue(OP_SRA,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1, 1'b0);

    // Multiply
    issue(OP_MUL,   32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33, 1'b0);
    issue(OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 33, 1'b0);
    issue(OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 1'b0);
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);

    // Divide
    issue(OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, 1'b0);
    issue(OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, 1'b0);
    issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1'b0);
    issue(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b0);
    issue(OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b0);
    issue(OP_REM,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b0);
    issue(OP_DIVU, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 33, 1'b0);
    issue(OP_REMU, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33, 1'b0);

    // Divide by zero
    issue(OP_DIVU, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1, 1'b0);
    issue(OP_REMU, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1, 1'b0);
    issue(OP_DIV,  32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 1, 1'b0);
    issue(OP_REM,  32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1, 1'b0);

    // in_valid held high with changing operands while busy
    issue(OP_MUL, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 33, 1'b1);
    issue(OP_ADD, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1, 1'b1);

    // Reset in the middle of a divide
    dn = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && dn < 50) begin
      @(negedge clk);
      dn++;
    end
    bus.in_valid   = 1'b1;
    bus.SrcA       = 32'h0000_0064;
    bus.SrcB       = 32'h0000_0007;
    bus.ALUControl = OP_DIV;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_result", bus.ALUResult, 32'h0);
    check("midrst_zero", W'(bus.Zero), W'(1));
    check("midrst_done", W'(bus.done), W'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_ready", W'(bus.in_ready), W'(1));
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
    end
    check("midrst_no_done", W'(dn), W'(0));
    issue(OP_ADD, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_empty", W'(exp_q.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
